// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants,
// depth helper and parameter range checks.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

    function automatic bit afull_th_ok(input int th, input int depth);
        return (th >= 1) && (th <= depth);
    endfunction

    function automatic bit aempty_th_ok(input int th, input int depth);
        return (th >= 0) && (th <= depth - 1);
    endfunction

    function automatic bit fifo_mode_ok(input int mode);
        return (mode == FIFO_STD) || (mode == FIFO_FWFT);
    endfunction

endpackage

// File: rtl/sync_fifo_flagged_if.sv
// Producer/consumer handshake bundle for sync_fifo_flagged.
// master = user side, slave = FIFO side.
interface sync_fifo_flagged_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
);
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             wfull;
    logic             rempty;
    logic             walmost_full;
    logic             ralmost_empty;
    logic [ASIZE:0]   count;
    logic             overflow;
    logic             underflow;

    modport master (
        output winc, wdata, rinc,
        input  rdata, wfull, rempty, walmost_full,
        input  ralmost_empty, count, overflow, underflow
    );

    modport slave (
        input  winc, wdata, rinc,
        output rdata, wfull, rempty, walmost_full,
        output ralmost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port and one
// asynchronous read port. Contents are never reset.
module sync_fifo_mem #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);
    logic [DSIZE-1:0] mem [2**ASIZE];

    // write accepted words
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with fill count, almost flags,
// sticky error flags and optional first-word-fall-through.
module sync_fifo_flagged
    import fifo_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input logic               clk,
    input logic               rst_n,
    sync_fifo_flagged_if.slave bus
);
    localparam int DEPTH = fifo_depth(ASIZE);
    localparam logic [ASIZE:0] DEP = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AF  = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] AE  = (ASIZE+1)'(AEMPTY_TH);
    localparam logic [ASIZE:0] ONE = (ASIZE+1)'(1);
    localparam logic [ASIZE:0] ZRO = '0;

    if (!afull_th_ok(AFULL_TH, DEPTH)) begin : g_bad_afull
        $error("AFULL_TH out of range 1..DEPTH");
    end
    if (!aempty_th_ok(AEMPTY_TH, DEPTH)) begin : g_bad_aempty
        $error("AEMPTY_TH out of range 0..DEPTH-1");
    end
    if (!fifo_mode_ok(FWFT)) begin : g_bad_mode
        $error("FWFT must be 0 or 1");
    end

    logic [ASIZE:0]   wptr, rptr, cnt, cnt_nxt;
    logic             wr_acc, rd_acc;
    logic             full_q, empty_q, afull_q, aempty_q;
    logic             ovf_q, udf_q;
    logic [DSIZE-1:0] rd_word;

    // accept decisions use the flags as registered before the edge
    always_comb begin
        wr_acc  = bus.winc && !full_q;
        rd_acc  = bus.rinc && !empty_q;
        cnt_nxt = cnt + (wr_acc ? ONE : ZRO) - (rd_acc ? ONE : ZRO);
    end

    // pointers, count, flags and sticky errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + ONE;
            if (rd_acc) rptr <= rptr + ONE;
            cnt      <= cnt_nxt;
            full_q   <= (cnt_nxt == DEP);
            empty_q  <= (cnt_nxt == ZRO);
            afull_q  <= (cnt_nxt >= AF);
            aempty_q <= (cnt_nxt <= AE);
            if (bus.winc && full_q)  ovf_q <= 1'b1;
            if (bus.rinc && empty_q) udf_q <= 1'b1;
        end
    end

    sync_fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr[ASIZE-1:0]),
        .wdata (bus.wdata),
        .raddr (rptr[ASIZE-1:0]),
        .rdata (rd_word)
    );

    if (FWFT == FIFO_FWFT) begin : g_fwft
        // head word is presented directly
        assign bus.rdata = rd_word;
    end else begin : g_std
        logic [DSIZE-1:0] rdata_q;

        // capture the head word on each accepted read
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)      rdata_q <= '0;
            else if (rd_acc) rdata_q <= rd_word;
        end

        assign bus.rdata = rdata_q;
    end

    assign bus.wfull         = full_q;
    assign bus.rempty        = empty_q;
    assign bus.walmost_full  = afull_q;
    assign bus.ralmost_empty = aempty_q;
    assign bus.count         = cnt;
    assign bus.overflow      = ovf_q;
    assign bus.underflow     = udf_q;
endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Randomised bench: standard and FWFT instances driven in
// lockstep and compared against a queue-based model.
module tb_sync_fifo_flagged;
    localparam int DEPTH = 16;
    localparam int AFT   = 12;
    localparam int AET   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       winc = 1'b0;
    logic       rinc = 1'b0;
    logic [7:0] wdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic [7:0] m_rd  = '0;

    sync_fifo_flagged_if #(.DSIZE(8), .ASIZE(4)) bus_s ();
    sync_fifo_flagged_if #(.DSIZE(8), .ASIZE(4)) bus_f ();

    assign bus_s.winc  = winc;
    assign bus_s.wdata = wdata;
    assign bus_s.rinc  = rinc;
    assign bus_f.winc  = winc;
    assign bus_f.wdata = wdata;
    assign bus_f.rinc  = rinc;

    sync_fifo_flagged #(
        .DSIZE(8), .ASIZE(4), .AFULL_TH(AFT),
        .AEMPTY_TH(AET), .FWFT(0)
    ) u_std (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    sync_fifo_flagged #(
        .DSIZE(8), .ASIZE(4), .AFULL_TH(AFT),
        .AEMPTY_TH(AET), .FWFT(1)
    ) u_fwft (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_f.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count_s",  32'(bus_s.count), n);
        chk("count_f",  32'(bus_f.count), n);
        chk("wfull",    32'(bus_s.wfull), 32'(n == DEPTH));
        chk("rempty",   32'(bus_s.rempty), 32'(n == 0));
        chk("afull",    32'(bus_s.walmost_full), 32'(n >= AFT));
        chk("aempty",   32'(bus_s.ralmost_empty), 32'(n <= AET));
        chk("wfull_f",  32'(bus_f.wfull), 32'(n == DEPTH));
        chk("rempty_f", 32'(bus_f.rempty), 32'(n == 0));
        chk("ovf",      32'(bus_s.overflow), 32'(m_ovf));
        chk("udf",      32'(bus_s.underflow), 32'(m_udf));
        chk("ovf_f",    32'(bus_f.overflow), 32'(m_ovf));
        chk("udf_f",    32'(bus_f.underflow), 32'(m_udf));
        chk("rdata_s",  32'(bus_s.rdata), 32'(m_rd));
        if (n > 0) chk("rdata_f", 32'(bus_f.rdata), 32'(q[0]));
    endtask

    task automatic step(input logic w, input logic [7:0] d,
                        input logic r);
        bit wa, ra;
        winc  = w;
        wdata = d;
        rinc  = r;
        wa = w && (q.size() < DEPTH);
        ra = r && (q.size() > 0);
        if (w && q.size() == DEPTH) m_ovf = 1'b1;
        if (r && q.size() == 0)     m_udf = 1'b1;
        @(posedge clk);
        if (ra) m_rd = q.pop_front();
        if (wa) q.push_back(d);
        @(negedge clk);
        winc = 1'b0;
        rinc = 1'b0;
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_rd  = '0;
    endtask

    initial begin
        int bias_w, bias_r;
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // fill 0x00..0x0F
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        // write while full
        step(1'b1, 8'hAA, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        // drain, order and no 0xAA
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
        chk("last_rd", 32'(bus_s.rdata), 32'h0F);

        // standard-mode single word
        step(1'b1, 8'h5C, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("rd_5c", 32'(bus_s.rdata), 32'h5C);

        // FWFT head presentation
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        chk("fwft_11", 32'(bus_f.rdata), 32'h11);
        step(1'b0, 8'h00, 1'b1);
        chk("fwft_22", 32'(bus_f.rdata), 32'h22);
        step(1'b0, 8'h00, 1'b1);

        // simultaneous traffic at count 5
        for (int i = 0; i < 5; i++)
            step(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 40; i++)
            step(1'b1, 8'($urandom), 1'b1);
        chk("cnt5", 32'(bus_s.count), 32'd5);

        // random traffic with drifting bias
        for (int blk = 0; blk < 8; blk++) begin
            bias_w = (blk % 2 == 0) ? 80 : 25;
            bias_r = (blk % 2 == 0) ? 25 : 80;
            for (int i = 0; i < 50; i++)
                step(1'($urandom_range(99) < bias_w),
                     8'($urandom),
                     1'($urandom_range(99) < bias_r));
        end

        // go to count 9, then reset between edges
        while (q.size() > 0) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 1'b0);
        chk("cnt9", 32'(bus_s.count), 32'd9);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        chk("udf_post", 32'(bus_s.underflow), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
